// File: rtl/reorder_buffer.sv
// ============================================================================
// Module   : reorder_buffer
// Purpose  : Circular in-order commit buffer with CDB wakeup, operand lookup
//            and branch / jump-and-link mispredict flush.
// Options  : define ROB_BYPASS_EN to forward a same-cycle CDB result to queries
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reorder_buffer #(
   parameter int ROB_SIZE = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        issue_valid,
   input  logic [1:0]  issue_type,
   input  logic [4:0]  issue_rd,
   input  logic [31:0] issue_pc,
   input  logic        issue_pred_taken,
   output logic [4:0]  issue_tag,
   output logic        rob_full,
   input  logic        cdb_valid,
   input  logic [4:0]  cdb_tag,
   input  logic [31:0] cdb_value,
   input  logic        cdb_taken,
   input  logic [31:0] cdb_target,
   input  logic [4:0]  query1_tag,
   input  logic [4:0]  query2_tag,
   output logic        query1_ready,
   output logic        query2_ready,
   output logic [31:0] query1_value,
   output logic [31:0] query2_value,
   output logic        commit_valid,
   output logic [4:0]  commit_tag,
   output logic [1:0]  commit_type,
   output logic [4:0]  commit_rd,
   output logic [31:0] commit_value,
   output logic        flush_out,
   output logic [31:0] flush_pc
);

   localparam int         C_IDX_W       = $clog2(ROB_SIZE);
   localparam int         C_CNT_W       = $clog2(ROB_SIZE + 1);
   localparam logic [1:0] C_TYPE_BRANCH = 2'd2;
   localparam logic [1:0] C_TYPE_JAL    = 2'd3;

   logic [C_IDX_W-1:0]  r_head;
   logic [C_IDX_W-1:0]  r_tail;
   logic [C_CNT_W-1:0]  r_count;
   logic [ROB_SIZE-1:0] r_busy;
   logic [ROB_SIZE-1:0] r_ready;

   logic [1:0]          r_type   [ROB_SIZE];
   logic [4:0]          r_rd     [ROB_SIZE];
   logic [31:0]         r_pc     [ROB_SIZE];
   logic                r_pred   [ROB_SIZE];
   logic [31:0]         r_value  [ROB_SIZE];
   logic                r_taken  [ROB_SIZE];
   logic [31:0]         r_target [ROB_SIZE];

   // Tags are index + 1; zero and tags beyond the buffer never match.
   function automatic logic tag_valid(input logic [4:0] tag);
      return (tag != 5'd0) && ({1'b0, tag} <= 6'(ROB_SIZE));
   endfunction

   function automatic logic [C_IDX_W-1:0] tag_idx(input logic [4:0] tag);
      logic [4:0] t;
      t = tag - 5'd1;
      return C_IDX_W'(t);
   endfunction

   logic               w_issue;
   logic               w_commit;
   logic               w_cdb_hit;
   logic [C_IDX_W-1:0] w_cdb_idx;
   logic [31:0]        w_seq_pc;
   logic               w_taken_eff;
   logic               w_mispredict;
   logic [31:0]        w_redirect;
   logic               w_flush;

   assign issue_tag = 5'(r_tail) + 5'd1;
   assign rob_full  = (r_count == C_CNT_W'(ROB_SIZE));

   assign w_issue   = rdy_in & issue_valid & ~rob_full;
   assign w_cdb_idx = tag_idx(cdb_tag);
   assign w_cdb_hit = rdy_in & cdb_valid & tag_valid(cdb_tag)
                    & r_busy[w_cdb_idx] & ~r_ready[w_cdb_idx];
   assign w_commit  = rdy_in & r_busy[r_head] & r_ready[r_head];
   assign w_seq_pc  = r_pc[r_head] + 32'd4;

   // A jump-and-link counts as taken whenever it leaves the fall-through path.
   always_comb begin
      w_taken_eff  = r_taken[r_head];
      w_mispredict = 1'b0;
      if (r_type[r_head] == C_TYPE_BRANCH) begin
         w_mispredict = (r_taken[r_head] != r_pred[r_head]);
      end else if (r_type[r_head] == C_TYPE_JAL) begin
         w_taken_eff  = (r_target[r_head] != w_seq_pc);
         w_mispredict = (w_taken_eff != r_pred[r_head]);
      end
   end

   assign w_redirect = w_taken_eff ? r_target[r_head] : w_seq_pc;
   assign w_flush    = w_commit & w_mispredict;

   logic [4:0]  w_q_tag   [2];
   logic [1:0]  w_q_ready;
   logic [63:0] w_q_value;

   assign w_q_tag[0]   = query1_tag;
   assign w_q_tag[1]   = query2_tag;
   assign query1_ready = w_q_ready[0];
   assign query2_ready = w_q_ready[1];
   assign query1_value = w_q_value[31:0];
   assign query2_value = w_q_value[63:32];

   for (genvar g = 0; g < 2; g++) begin : g_query
      logic [C_IDX_W-1:0] w_idx;
      logic               w_hit;
      logic               w_stored;
      logic               w_byp;

      assign w_idx    = tag_idx(w_q_tag[g]);
      assign w_hit    = tag_valid(w_q_tag[g]) & r_busy[w_idx];
      assign w_stored = w_hit & r_ready[w_idx];
`ifdef ROB_BYPASS_EN
      assign w_byp    = w_hit & ~r_ready[w_idx] & cdb_valid & (cdb_tag == w_q_tag[g]);
`else
      assign w_byp    = 1'b0;
`endif
      assign w_q_ready[g]         = w_stored | w_byp;
      assign w_q_value[g*32 +: 32] = w_byp    ? cdb_value :
                                     w_stored ? r_value[w_idx] : 32'd0;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
         r_busy       <= '0;
         r_ready      <= '0;
         commit_valid <= 1'b0;
         commit_tag   <= 5'd0;
         commit_type  <= 2'd0;
         commit_rd    <= 5'd0;
         commit_value <= 32'd0;
         flush_out    <= 1'b0;
         flush_pc     <= 32'd0;
      end else if (!rdy_in) begin
         commit_valid <= 1'b0;
         flush_out    <= 1'b0;
      end else begin
         commit_valid <= w_commit;
         flush_out    <= w_flush;
         if (w_commit) begin
            commit_tag   <= 5'(r_head) + 5'd1;
            commit_type  <= r_type[r_head];
            commit_rd    <= r_rd[r_head];
            commit_value <= (r_type[r_head] == C_TYPE_JAL) ? w_seq_pc : r_value[r_head];
         end
         if (w_flush) begin
            flush_pc <= w_redirect;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_busy   <= '0;
            r_ready  <= '0;
         end else begin
            if (w_cdb_hit) begin
               r_ready[w_cdb_idx] <= 1'b1;
            end
            if (w_commit) begin
               r_busy[r_head] <= 1'b0;
               r_head         <= r_head + 1'b1;
            end
            if (w_issue) begin
               r_busy[r_tail]  <= 1'b1;
               r_ready[r_tail] <= 1'b0;
               r_tail          <= r_tail + 1'b1;
            end
            r_count <= r_count + C_CNT_W'(w_issue) - C_CNT_W'(w_commit);
         end
      end
   end

   // Payload needs no reset: busy/ready gate every use of it.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !w_flush) begin
         if (w_cdb_hit) begin
            r_value[w_cdb_idx]  <= cdb_value;
            r_taken[w_cdb_idx]  <= cdb_taken;
            r_target[w_cdb_idx] <= cdb_target;
         end
         if (w_issue) begin
            r_type[r_tail] <= issue_type;
            r_rd[r_tail]   <= issue_rd;
            r_pc[r_tail]   <= issue_pc;
            r_pred[r_tail] <= issue_pred_taken;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based reference model plus directed scenarios.
`default_nettype none

module tb_reorder_buffer;

   localparam int N = 16;
`ifdef ROB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        issue_valid, issue_pred_taken;
   logic [1:0]  issue_type;
   logic [4:0]  issue_rd, issue_tag;
   logic [31:0] issue_pc;
   logic        rob_full;
   logic        cdb_valid, cdb_taken;
   logic [4:0]  cdb_tag;
   logic [31:0] cdb_value, cdb_target;
   logic [4:0]  query1_tag, query2_tag;
   logic        query1_ready, query2_ready;
   logic [31:0] query1_value, query2_value;
   logic        commit_valid, flush_out;
   logic [4:0]  commit_tag, commit_rd;
   logic [1:0]  commit_type;
   logic [31:0] commit_value, flush_pc;

   reorder_buffer #(.ROB_SIZE(N)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
      .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
      .issue_tag(issue_tag), .rob_full(rob_full),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_taken(cdb_taken), .cdb_target(cdb_target),
      .query1_tag(query1_tag), .query2_tag(query2_tag),
      .query1_ready(query1_ready), .query2_ready(query2_ready),
      .query1_value(query1_value), .query2_value(query2_value),
      .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_type(commit_type),
      .commit_rd(commit_rd), .commit_value(commit_value),
      .flush_out(flush_out), .flush_pc(flush_pc)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [4:0]  tag;
      logic [1:0]  typ;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        pred;
      logic        rdy;
      logic [31:0] val;
      logic        taken;
      logic [31:0] tgt;
   } ent_t;

   ent_t        q[$];
   int          next_tag;
   int          errors = 0;
   int          checks = 0;
   logic        exp_cv, exp_fl;
   logic [4:0]  exp_ctag, exp_crd;
   logic [1:0]  exp_ctype;
   logic [31:0] exp_cval, exp_fpc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      next_tag = 1;
      exp_cv   = 1'b0;
      exp_fl   = 1'b0;
   endtask

   function automatic void model_query(input logic [4:0] t, output logic r, output logic [31:0] v);
      r = 1'b0;
      v = 32'd0;
      if (t == 5'd0) return;
      foreach (q[i]) begin
         if (q[i].tag == t) begin
            if (q[i].rdy) begin
               r = 1'b1;
               v = q[i].val;
            end else if (BYP && cdb_valid && cdb_tag == t) begin
               r = 1'b1;
               v = cdb_value;
            end
         end
      end
   endfunction

   task automatic check_comb();
      logic        r;
      logic [31:0] v;
      chk("issue_tag", {27'd0, issue_tag}, next_tag);
      chk("rob_full", {31'd0, rob_full}, {31'd0, q.size() == N});
      model_query(query1_tag, r, v);
      chk("query1_ready", {31'd0, query1_ready}, {31'd0, r});
      chk("query1_value", query1_value, v);
      model_query(query2_tag, r, v);
      chk("query2_ready", {31'd0, query2_ready}, {31'd0, r});
      chk("query2_value", query2_value, v);
   endtask

   // Predict the effect of the coming rising edge from the current inputs.
   task automatic model_edge();
      int   pre;
      logic fire, misp, tk;
      ent_t e;
      exp_cv = 1'b0;
      exp_fl = 1'b0;
      if (!rdy_in) return;
      pre  = q.size();
      fire = (pre > 0) && q[0].rdy;
      misp = 1'b0;
      if (fire) begin
         e         = q[0];
         exp_cv    = 1'b1;
         exp_ctag  = e.tag;
         exp_ctype = e.typ;
         exp_crd   = e.rd;
         exp_cval  = (e.typ == 2'd3) ? e.pc + 32'd4 : e.val;
         if (e.typ == 2'd2) begin
            misp    = (e.taken != e.pred);
            exp_fpc = e.taken ? e.tgt : e.pc + 32'd4;
         end else if (e.typ == 2'd3) begin
            tk      = (e.tgt != e.pc + 32'd4);
            misp    = (tk != e.pred);
            exp_fpc = tk ? e.tgt : e.pc + 32'd4;
         end
      end
      if (misp) begin
         exp_fl = 1'b1;
         q.delete();
         next_tag = 1;
         return;
      end
      if (cdb_valid) begin
         foreach (q[i]) begin
            if (q[i].tag == cdb_tag && !q[i].rdy) begin
               q[i].rdy   = 1'b1;
               q[i].val   = cdb_value;
               q[i].taken = cdb_taken;
               q[i].tgt   = cdb_target;
            end
         end
      end
      if (fire) void'(q.pop_front());
      if (issue_valid && pre < N) begin
         e.tag  = 5'(next_tag);
         e.typ  = issue_type;
         e.rd   = issue_rd;
         e.pc   = issue_pc;
         e.pred = issue_pred_taken;
         e.rdy  = 1'b0;
         e.val  = 32'd0;
         e.taken = 1'b0;
         e.tgt  = 32'd0;
         q.push_back(e);
         next_tag = next_tag % N + 1;
      end
   endtask

   task automatic check_regs();
      chk("commit_valid", {31'd0, commit_valid}, {31'd0, exp_cv});
      chk("flush_out", {31'd0, flush_out}, {31'd0, exp_fl});
      if (exp_cv) begin
         chk("commit_tag", {27'd0, commit_tag}, {27'd0, exp_ctag});
         chk("commit_type", {30'd0, commit_type}, {30'd0, exp_ctype});
         chk("commit_rd", {27'd0, commit_rd}, {27'd0, exp_crd});
         chk("commit_value", commit_value, exp_cval);
      end
      if (exp_fl) chk("flush_pc", flush_pc, exp_fpc);
   endtask

   task automatic cycle();
      @(negedge clk_in);
      check_comb();
      model_edge();
      @(posedge clk_in);
      #1;
      check_regs();
   endtask

   task automatic iss(input logic [1:0] ty, input logic [4:0] rd, input logic [31:0] pc, input logic pr);
      issue_valid = 1'b1; issue_type = ty; issue_rd = rd; issue_pc = pc; issue_pred_taken = pr;
      cycle();
      issue_valid = 1'b0;
   endtask

   task automatic cdb(input logic [4:0] t, input logic [31:0] v, input logic tk, input logic [31:0] tg);
      cdb_valid = 1'b1; cdb_tag = t; cdb_value = v; cdb_taken = tk; cdb_target = tg;
      cycle();
      cdb_valid = 1'b0;
   endtask

   task automatic idle();
      cycle();
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1;
      issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_pc = 32'd0; issue_pred_taken = 1'b0;
      cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_value = 32'd0; cdb_taken = 1'b0; cdb_target = 32'd0;
      query1_tag = 5'd0; query2_tag = 5'd0;
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
      chk("rst_commit_tag", {27'd0, commit_tag}, 32'd0);
      chk("rst_commit_value", commit_value, 32'd0);
      chk("rst_flush_out", {31'd0, flush_out}, 32'd0);
      chk("rst_flush_pc", flush_pc, 32'd0);
      chk("rst_issue_tag", {27'd0, issue_tag}, 32'd1);
      chk("rst_rob_full", {31'd0, rob_full}, 32'd0);
      rst_in = 1'b0;

      // Three register ops, then out-of-order completion.
      iss(2'd1, 5'd1, 32'h1000, 1'b0);
      iss(2'd1, 5'd2, 32'h1004, 1'b0);
      iss(2'd1, 5'd3, 32'h1008, 1'b0);
      chk("lit_issue_tag_after3", {27'd0, issue_tag}, 32'd4);
      chk("lit_no_commit", {31'd0, commit_valid}, 32'd0);
      cdb(5'd2, 32'h55, 1'b0, 32'd0);
      cdb(5'd1, 32'h11, 1'b0, 32'd0);
      idle();
      chk("lit_c1_tag", {27'd0, commit_tag}, 32'd1);
      chk("lit_c1_value", commit_value, 32'h11);
      chk("lit_c1_rd", {27'd0, commit_rd}, 32'd1);
      idle();
      chk("lit_c2_tag", {27'd0, commit_tag}, 32'd2);
      chk("lit_c2_value", commit_value, 32'h55);
      idle();
      chk("lit_tag3_held", {31'd0, commit_valid}, 32'd0);
      cdb(5'd3, 32'h33, 1'b0, 32'd0);
      idle();

      // Stall with a ready head; issue attempts during the stall are ignored.
      iss(2'd0, 5'd4, 32'h2000, 1'b0);
      cdb(5'd4, 32'h44, 1'b0, 32'd0);
      rdy_in = 1'b0;
      repeat (3) iss(2'd1, 5'd9, 32'h2100, 1'b0);
      chk("lit_stall_no_commit", {31'd0, commit_valid}, 32'd0);
      rdy_in = 1'b1;
      idle();
      chk("lit_after_stall_commit", {31'd0, commit_valid}, 32'd1);
      chk("lit_after_stall_tag", {27'd0, commit_tag}, 32'd4);

      // Operand lookup with a same-cycle CDB write.
      iss(2'd1, 5'd5, 32'h3000, 1'b0);
      iss(2'd1, 5'd6, 32'h3004, 1'b0);
      query1_tag = 5'd6; query2_tag = 5'd5;
      cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_value = 32'hABCD; cdb_taken = 1'b0; cdb_target = 32'd0;
      #1;
      chk("lit_query_same_cycle", {31'd0, query1_ready}, {31'd0, BYP});
      cycle();
      cdb_valid = 1'b0;
      chk("lit_query_next_ready", {31'd0, query1_ready}, 32'd1);
      chk("lit_query_next_value", query1_value, 32'hABCD);
      idle();
      cdb(5'd5, 32'h5, 1'b0, 32'd0);
      idle();
      idle();
      query1_tag = 5'd0; query2_tag = 5'd0;

      // Correct jal, correct taken branch, then a mispredicted branch.
      iss(2'd3, 5'd1, 32'h40, 1'b0);
      cdb(5'd7, 32'd0, 1'b0, 32'h44);
      idle();
      chk("lit_jal_link", commit_value, 32'h44);
      chk("lit_jal_noflush", {31'd0, flush_out}, 32'd0);
      iss(2'd2, 5'd0, 32'h80, 1'b1);
      cdb(5'd8, 32'd0, 1'b1, 32'h90);
      idle();
      chk("lit_br_ok_noflush", {31'd0, flush_out}, 32'd0);
      iss(2'd2, 5'd0, 32'h100, 1'b0);
      iss(2'd1, 5'd10, 32'h104, 1'b0);
      iss(2'd1, 5'd11, 32'h108, 1'b0);
      cdb(5'd10, 32'h77, 1'b0, 32'd0);
      cdb(5'd9, 32'd0, 1'b1, 32'h200);
      issue_valid = 1'b1; issue_type = 2'd1; issue_rd = 5'd12; issue_pc = 32'h10C;
      cdb_valid = 1'b1; cdb_tag = 5'd11; cdb_value = 32'h99;
      cycle();
      issue_valid = 1'b0; cdb_valid = 1'b0;
      chk("lit_flush_out", {31'd0, flush_out}, 32'd1);
      chk("lit_flush_pc", flush_pc, 32'h200);
      chk("lit_flush_commit_tag", {27'd0, commit_tag}, 32'd9);
      idle();
      chk("lit_flush_once", {31'd0, flush_out}, 32'd0);
      chk("lit_younger_dropped", {31'd0, commit_valid}, 32'd0);
      chk("lit_tag_after_flush", {27'd0, issue_tag}, 32'd1);
      iss(2'd3, 5'd1, 32'h50, 1'b0);
      cdb(5'd1, 32'd0, 1'b0, 32'h300);
      idle();
      chk("lit_jal_flush_pc", flush_pc, 32'h300);
      chk("lit_jal_flush_link", commit_value, 32'h54);

      // Fill, overflow, then wrap-around allocation.
      for (int i = 0; i < N; i++) iss(2'd1, 5'(i + 1), 32'h4000 + 32'(i * 4), 1'b0);
      chk("lit_full", {31'd0, rob_full}, 32'd1);
      iss(2'd1, 5'd31, 32'h5000, 1'b0);
      cdb(5'd1, 32'hA1, 1'b0, 32'd0);
      issue_valid = 1'b1; issue_type = 2'd1; issue_rd = 5'd20; issue_pc = 32'h5004;
      cdb(5'd2, 32'hA2, 1'b0, 32'd0);
      chk("lit_full_commit_tag", {27'd0, commit_tag}, 32'd1);
      iss(2'd1, 5'd21, 32'h5008, 1'b0);
      chk("lit_wrap_commit_tag", {27'd0, commit_tag}, 32'd2);
      chk("lit_wrap_issue_tag", {27'd0, issue_tag}, 32'd2);
      iss(2'd1, 5'd22, 32'h500C, 1'b0);
      chk("lit_refull", {31'd0, rob_full}, 32'd1);

      // Asynchronous reset while a commit pulse is showing.
      cdb(5'd3, 32'h33, 1'b0, 32'd0);
      idle();
      chk("lit_pre_reset_commit", {31'd0, commit_valid}, 32'd1);
      #2 rst_in = 1'b1;
      #1;
      chk("lit_async_commit_valid", {31'd0, commit_valid}, 32'd0);
      chk("lit_async_rob_full", {31'd0, rob_full}, 32'd0);
      chk("lit_async_issue_tag", {27'd0, issue_tag}, 32'd1);
      model_reset();
      @(posedge clk_in);
      #1 rst_in = 1'b0;
      iss(2'd1, 5'd7, 32'h6000, 1'b0);
      cdb(5'd1, 32'hBEEF, 1'b0, 32'd0);
      idle();
      chk("lit_post_reset_tag", {27'd0, commit_tag}, 32'd1);
      chk("lit_post_reset_value", commit_value, 32'hBEEF);
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
